pc_fetch_register: RTL and testbench

Program-counter state holder at the fetch end of the next-PC path. Receives `PC_Next`, `BranchSig` and `Branched` from the PC update logic, holds the architectural PC, and returns `PC_plus_four` to it every cycle. Handles stall, halt and misaligned-target fault, and keeps cycle and branch statistics for the board display. Sits between the next-PC logic and instruction memory in the single-cycle CPU.

---
 rtl/pc_fetch_register.sv | 137 +++++++++++++
 tb/tb_pc_fetch_register.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_register.sv
// Fetch-end program counter: holds the architectural PC, handles stall/halt/misaligned-target fault.
// Optional statistics counters are built only when PC_FETCH_STATS_EN is defined.
module pc_fetch_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_Next,
  input  logic             BranchSig,
  input  logic             Branched,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             Go,
  output logic [31:0]      PC,
  output logic [31:0]      PC_plus_four,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  localparam int unsigned   PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            fault_q, fault_d;
  logic            cycle_inc, branch_inc, taken_inc;
  logic            misaligned;

  // Only a taken redirect can carry a misaligned target; the sequential path is always aligned.
  assign misaligned = Branched && (PC_Next[1:0] != 2'b00);

  // Next-state, next-PC and statistics strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cycle_inc  = 1'b0;
    branch_inc = 1'b0;
    taken_inc  = 1'b0;
    case (state_q)
      ST_RUN: begin
        cycle_inc = 1'b1;
        if (Halt) begin
          state_d = ST_HALT;
        end else if (!Stall) begin
          branch_inc = BranchSig;
          taken_inc  = Branched;
          if (misaligned) begin
            state_d = ST_FAULT;
          end else begin
            pc_d = PC_Next;
          end
        end
      end
      ST_HALT: begin
        if (Go) begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    halted_d = (state_d != ST_RUN);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign PC           = pc_q;
  assign PC_plus_four = pc_q + PC_STEP;
  assign Halted       = halted_q;
  assign Fault        = fault_q;

`ifdef PC_FETCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cycle_q, branch_q, taken_q;

  // Saturating statistics counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q  <= '0;
      branch_q <= '0;
      taken_q  <= '0;
    end else begin
      if (cycle_inc && (cycle_q != CNT_MAX)) begin
        cycle_q <= cycle_q + CNT_ONE;
      end
      if (branch_inc && (branch_q != CNT_MAX)) begin
        branch_q <= branch_q + CNT_ONE;
      end
      if (taken_inc && (taken_q != CNT_MAX)) begin
        taken_q <= taken_q + CNT_ONE;
      end
    end
  end

  assign CycleCnt  = cycle_q;
  assign BranchCnt = branch_q;
  assign TakenCnt  = taken_q;
`else
  logic unused_stats;
  assign unused_stats = ^{cycle_inc, branch_inc, taken_inc};

  assign CycleCnt  = '0;
  assign BranchCnt = '0;
  assign TakenCnt  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_register.sv
// Bench for pc_fetch_register: directed scenarios plus randomized run against a behavioural model.
module tb_pc_fetch_register;

`ifdef PC_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        branch_sig, branched, stall, halt, go;

  logic [31:0] pc, pc_plus_four;
  logic        halted, fault;
  logic [31:0] cycle_cnt, branch_cnt, taken_cnt;
  logic [31:0] s_pc, s_ppf;
  logic        s_halted, s_fault;
  logic [3:0]  s_cycle, s_branch, s_taken;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0]     m_pc;
  bit              m_halted, m_fault;
  longint unsigned m_cyc, m_br, m_tk;

  always #5 clk = ~clk;

  pc_fetch_register #(.RESET_VECTOR(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .PC_Next(pc_next), .BranchSig(branch_sig), .Branched(branched),
    .Stall(stall), .Halt(halt), .Go(go), .PC(pc), .PC_plus_four(pc_plus_four),
    .Halted(halted), .Fault(fault), .CycleCnt(cycle_cnt), .BranchCnt(branch_cnt), .TakenCnt(taken_cnt)
  );

  pc_fetch_register #(.RESET_VECTOR(32'h0), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .PC_Next(pc_next), .BranchSig(branch_sig), .Branched(branched),
    .Stall(stall), .Halt(halt), .Go(go), .PC(s_pc), .PC_plus_four(s_ppf),
    .Halted(s_halted), .Fault(s_fault), .CycleCnt(s_cycle), .BranchCnt(s_branch), .TakenCnt(s_taken)
  );

  function automatic longint unsigned exp_cnt(input longint unsigned c, input int unsigned w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    if (!STATS) return 64'd0;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0; m_fault = 1'b0;
    m_cyc = 0; m_br = 0; m_tk = 0;
  endtask

  // Architectural effect of one clock edge given the currently driven inputs.
  task automatic model_edge();
    if (!m_halted) begin
      m_cyc++;
      if (halt) m_halted = 1'b1;
      else if (!stall) begin
        if (branch_sig) m_br++;
        if (branched) m_tk++;
        if (branched && (pc_next % 4 != 0)) begin
          m_halted = 1'b1;
          m_fault  = 1'b1;
        end else m_pc = pc_next;
      end
    end else if (!m_fault && go) begin
      m_halted = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] nxt, input logic bs, input logic bd,
                       input logic st, input logic hl, input logic g);
    pc_next = nxt; branch_sig = bs; branched = bd; stall = st; halt = hl; go = g;
  endtask

  task automatic test_reset();
    drive(32'h0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else n_pass++;
    n_total++; if (pc_plus_four !== 32'h4) $display("FAIL reset_ppf got %h want %h", pc_plus_four, 32'h4); else n_pass++;
    n_total++; if ({halted, fault} !== 2'b00) $display("FAIL reset_flags got %b want 00", {halted, fault}); else n_pass++;
    n_total++; if ({cycle_cnt, branch_cnt, taken_cnt} !== 96'h0) $display("FAIL reset_cnts got %h/%h/%h want 0", cycle_cnt, branch_cnt, taken_cnt); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      drive(m_pc + 32'd4, 0, 0, 0, 0, 0);
      tick();
      n_total++; if (pc !== 32'(4 * (i + 1))) $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 32'(4 * (i + 1))); else n_pass++;
    end
    n_total++; if (cycle_cnt !== 32'(exp_cnt(5, 32))) $display("FAIL seq_cycle got %0d want %0d", cycle_cnt, exp_cnt(5, 32)); else n_pass++;
    n_total++; if (branch_cnt !== 32'h0) $display("FAIL seq_branch got %0d want 0", branch_cnt); else n_pass++;
  endtask

  task automatic test_branch();
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(m_pc + 32'd4, 0, 0, 0, 0, 0);
      tick();
    end
    n_total++; if (pc !== 32'h8) $display("FAIL br_start got %h want %h", pc, 32'h8); else n_pass++;
    drive(32'h40, 1, 1, 0, 0, 0);
    tick();
    n_total++; if (pc !== 32'h40) $display("FAIL br_taken_pc got %h want %h", pc, 32'h40); else n_pass++;
    n_total++; if ({branch_cnt, taken_cnt} !== {32'(exp_cnt(1, 32)), 32'(exp_cnt(1, 32))}) $display("FAIL br_taken_cnt got %0d/%0d want %0d/%0d", branch_cnt, taken_cnt, exp_cnt(1, 32), exp_cnt(1, 32)); else n_pass++;
    drive(32'h44, 1, 0, 0, 0, 0);
    tick();
    n_total++; if ({branch_cnt, taken_cnt} !== {32'(exp_cnt(2, 32)), 32'(exp_cnt(1, 32))}) $display("FAIL br_nt_cnt got %0d/%0d want %0d/%0d", branch_cnt, taken_cnt, exp_cnt(2, 32), exp_cnt(1, 32)); else n_pass++;
    n_total++; if (pc !== 32'h44) $display("FAIL br_nt_pc got %h want %h", pc, 32'h44); else n_pass++;
    drive(32'h40, 1, 1, 0, 0, 0);
    tick();
  endtask

  task automatic test_stall_halt();
    longint unsigned c0;
    c0 = m_cyc;
    // Stall must win over a misaligned taken redirect.
    for (int i = 0; i < 3; i++) begin
      drive(32'h82, 1, 1, 1, 0, 0);
      tick();
      n_total++; if ({pc, fault} !== {32'h40, 1'b0}) $display("FAIL stall_pc[%0d] got %h/%b want 40/0", i, pc, fault); else n_pass++;
    end
    n_total++; if (cycle_cnt !== 32'(exp_cnt(c0 + 3, 32))) $display("FAIL stall_cycle got %0d want %0d", cycle_cnt, exp_cnt(c0 + 3, 32)); else n_pass++;
    n_total++; if (taken_cnt !== 32'(exp_cnt(m_tk, 32))) $display("FAIL stall_taken got %0d want %0d", taken_cnt, exp_cnt(m_tk, 32)); else n_pass++;
    drive(32'h80, 0, 0, 1, 1, 0);
    tick();
    n_total++; if ({halted, fault, pc} !== {2'b10, 32'h40}) $display("FAIL halt_enter got %b%b/%h want 10/40", halted, fault, pc); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 0, 0, 0, 0, 0);
      tick();
    end
    n_total++; if ({halted, pc} !== {1'b1, 32'h40}) $display("FAIL halt_hold got %b/%h want 1/40", halted, pc); else n_pass++;
    n_total++; if (cycle_cnt !== 32'(exp_cnt(c0 + 4, 32))) $display("FAIL halt_cycle got %0d want %0d", cycle_cnt, exp_cnt(c0 + 4, 32)); else n_pass++;
    drive(32'h100, 0, 0, 0, 0, 1);
    tick();
    n_total++; if ({halted, pc} !== {1'b0, 32'h40}) $display("FAIL go_resume got %b/%h want 0/40", halted, pc); else n_pass++;
    drive(32'h44, 0, 0, 0, 0, 0);
    tick();
    n_total++; if (pc !== 32'h44) $display("FAIL go_advance got %h want %h", pc, 32'h44); else n_pass++;
  endtask

  task automatic test_fault();
    drive(32'h42, 1, 1, 0, 0, 0);
    tick();
    n_total++; if ({halted, fault, pc} !== {2'b11, 32'h44}) $display("FAIL fault_enter got %b%b/%h want 11/44", halted, fault, pc); else n_pass++;
    n_total++; if (taken_cnt !== 32'(exp_cnt(m_tk, 32))) $display("FAIL fault_taken got %0d want %0d", taken_cnt, exp_cnt(m_tk, 32)); else n_pass++;
    drive(32'h80, 0, 0, 0, 0, 1);
    tick();
    n_total++; if ({halted, fault, pc} !== {2'b11, 32'h44}) $display("FAIL fault_go got %b%b/%h want 11/44", halted, fault, pc); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if ({halted, fault, pc, cycle_cnt} !== {2'b00, 32'h0, 32'h0}) $display("FAIL fault_rst got %b%b/%h/%0d want 00/0/0", halted, fault, pc, cycle_cnt); else n_pass++;
    rst = 1'b0;
    model_reset();
    drive(32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    drive(32'hFFFF_FFFC, 1, 1, 0, 0, 0);
    tick();
    n_total++; if ({pc, pc_plus_four} !== {32'hFFFF_FFFC, 32'h0}) $display("FAIL wrap_ppf got %h/%h want fffffffc/0", pc, pc_plus_four); else n_pass++;
    drive(m_pc + 32'd4, 0, 0, 0, 0, 0);
    tick();
    n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(32'h8, 1, 1, 1, 0, 0);
      tick();
    end
    n_total++; if (s_cycle !== (STATS ? 4'hF : 4'h0)) $display("FAIL sat_cycle got %h want %h", s_cycle, STATS ? 4'hF : 4'h0); else n_pass++;
    n_total++; if (cycle_cnt !== 32'(exp_cnt(m_cyc, 32))) $display("FAIL sat_wide got %0d want %0d", cycle_cnt, exp_cnt(m_cyc, 32)); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(32'h40, 1, 1, 0, 0, 0);
    tick();
    n_total++; if (pc !== 32'h40) $display("FAIL arst_pre got %h want 40", pc); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if ({pc, pc_plus_four} !== {32'h0, 32'h4}) $display("FAIL arst_pc got %h/%h want 0/4", pc, pc_plus_four); else n_pass++;
    n_total++; if ({cycle_cnt, s_branch, s_taken} !== 40'h0) $display("FAIL arst_cnt got %0d/%0d/%0d want 0", cycle_cnt, s_branch, s_taken); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic        bs;
    for (int i = 0; i < 400; i++) begin
      if (m_fault && ($urandom_range(0, 3) == 0)) begin
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
      end
      r  = $urandom();
      bs = ($urandom_range(0, 2) == 0);
      drive({r[31:2], ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00},
            bs, bs ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0),
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4, $urandom_range(0, 3) == 0);
      tick();
      n_total++; if ({pc, pc_plus_four} !== {m_pc, m_pc + 32'd4}) $display("FAIL rnd_pc[%0d] got %h/%h want %h", i, pc, pc_plus_four, m_pc); else n_pass++;
      n_total++; if ({halted, fault} !== {m_halted, m_fault}) $display("FAIL rnd_flags[%0d] got %b%b want %b%b", i, halted, fault, m_halted, m_fault); else n_pass++;
      n_total++; if (cycle_cnt !== 32'(exp_cnt(m_cyc, 32))) $display("FAIL rnd_cycle[%0d] got %0d want %0d", i, cycle_cnt, exp_cnt(m_cyc, 32)); else n_pass++;
      n_total++; if (branch_cnt !== 32'(exp_cnt(m_br, 32))) $display("FAIL rnd_branch[%0d] got %0d want %0d", i, branch_cnt, exp_cnt(m_br, 32)); else n_pass++;
      n_total++; if (taken_cnt !== 32'(exp_cnt(m_tk, 32))) $display("FAIL rnd_taken[%0d] got %0d want %0d", i, taken_cnt, exp_cnt(m_tk, 32)); else n_pass++;
      n_total++; if ({s_cycle, s_branch, s_taken} !== {4'(exp_cnt(m_cyc, 4)), 4'(exp_cnt(m_br, 4)), 4'(exp_cnt(m_tk, 4))})
        $display("FAIL rnd_small[%0d] got %h/%h/%h want %h/%h/%h", i, s_cycle, s_branch, s_taken, exp_cnt(m_cyc, 4), exp_cnt(m_br, 4), exp_cnt(m_tk, 4)); else n_pass++;
      n_total++; if ({s_pc, s_halted, s_fault} !== {m_pc, m_halted, m_fault}) $display("FAIL rnd_small_pc[%0d] got %h want %h", i, s_pc, m_pc); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_halt();
    test_fault();
    test_wrap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
